rs_age_issue: RTL and testbench

Parametrised reservation station: successor to the fixed 3-wide RS. Accepts up to DP_WIDTH dispatched instructions per cycle and tracks source-operand readiness via CDB_WIDTH result-broadcast lanes. Issues up to IS_WIDTH ready entries per cycle, oldest first, under per-functional-unit-class availability caps. Sits between dispatch/map-table/ROB (upstream) and the FU issue stage (downstream).

---
 rtl/rs_age_issue.sv | 194 +++++++++++++++++++
 tb/tb_rs_age_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_issue.sv
// rs_age_issue: multi-wide reservation station with CDB wakeup and per-class capped select.
// RS_AGE_ORDER_EN selects oldest-first via an age matrix; otherwise lowest index wins.
module rs_age_issue #(
    parameter int RS_DEPTH   = 16,
    parameter int DP_WIDTH   = 3,
    parameter int IS_WIDTH   = 3,
    parameter int CDB_WIDTH  = 3,
    parameter int TAG_W      = 5,
    parameter int XLEN       = 32,
    parameter int PAYLOAD_W  = 64,
    parameter int FU_CLASSES = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         squash,
    input  logic [DP_WIDTH-1:0]                          dp_valid,
    input  logic [DP_WIDTH-1:0][TAG_W-1:0]               dp_tag,
    input  logic [DP_WIDTH-1:0][1:0]                     dp_src_rdy,
    input  logic [DP_WIDTH-1:0][1:0][TAG_W-1:0]          dp_src_tag,
    input  logic [DP_WIDTH-1:0][1:0][XLEN-1:0]           dp_src_val,
    input  logic [DP_WIDTH-1:0][1:0]                     dp_fu,
    input  logic [DP_WIDTH-1:0][PAYLOAD_W-1:0]           dp_payload,
    input  logic [CDB_WIDTH-1:0]                         cdb_valid,
    input  logic [CDB_WIDTH-1:0][TAG_W-1:0]              cdb_tag,
    input  logic [CDB_WIDTH-1:0][XLEN-1:0]               cdb_val,
    input  logic [FU_CLASSES-1:0][$clog2(IS_WIDTH+1)-1:0] fu_avail,
    output logic [$clog2(DP_WIDTH+1)-1:0]                free_num,
    output logic [IS_WIDTH-1:0]                          is_valid,
    output logic [IS_WIDTH-1:0][TAG_W-1:0]               is_tag,
    output logic [IS_WIDTH-1:0][1:0][XLEN-1:0]           is_src_val,
    output logic [IS_WIDTH-1:0][1:0]                     is_fu,
    output logic [IS_WIDTH-1:0][PAYLOAD_W-1:0]           is_payload,
    output logic                                         overflow_err
);
    localparam int AW = $clog2(IS_WIDTH+1);
    localparam int NW = $clog2(DP_WIDTH+1);
    localparam int IW = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]                 valid_q, valid_d;
    logic [RS_DEPTH-1:0][TAG_W-1:0]      tag_q, tag_d;
    logic [RS_DEPTH-1:0][1:0]            rdy_q, rdy_d;
    logic [RS_DEPTH-1:0][1:0][TAG_W-1:0] stag_q, stag_d;
    logic [RS_DEPTH-1:0][1:0][XLEN-1:0]  val_q, val_d;
    logic [RS_DEPTH-1:0][1:0]            fu_q, fu_d;
    logic [RS_DEPTH-1:0][PAYLOAD_W-1:0]  pay_q, pay_d;
    logic                                ovf_q, ovf_d;
`ifdef RS_AGE_ORDER_EN
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]   age_q, age_d;
`endif

    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]   older;
    logic [RS_DEPTH-1:0]                 issued, cand, alloc;
    logic [FU_CLASSES-1:0][AW-1:0]       used;
    logic                                hit, slot_hit;
    logic [IW-1:0]                       sel, slot;

    assign free_num     = ($countones(~valid_q) >= DP_WIDTH) ? NW'(DP_WIDTH) : NW'($countones(~valid_q));
    assign overflow_err = ovf_q;

    // older[i] holds the entries that must win over entry i
    always_comb begin
        older = '0;
        for (int i = 0; i < RS_DEPTH; i++)
`ifdef RS_AGE_ORDER_EN
            older[i] = age_q[i];
`else
            older[i] = (RS_DEPTH'(1) << i) - RS_DEPTH'(1);
`endif
    end

    always_comb begin
        issued = '0;
        used = '0;
        cand = '0;
        hit = 1'b0;
        sel = '0;
        is_valid = '0;
        is_tag = '0;
        is_src_val = '0;
        is_fu = '0;
        is_payload = '0;
        for (int k = 0; k < IS_WIDTH; k++) begin
            for (int i = 0; i < RS_DEPTH; i++)
                cand[i] = !squash && valid_q[i] && (&rdy_q[i]) && !issued[i] && (used[fu_q[i]] < fu_avail[fu_q[i]]);
            hit = 1'b0;
            sel = '0;
            for (int i = RS_DEPTH - 1; i >= 0; i--)
                if (cand[i] && !(|(cand & older[i]))) begin
                    hit = 1'b1;
                    sel = IW'(i);
                end
            if (hit) begin
                issued[sel] = 1'b1;
                used[fu_q[sel]] = used[fu_q[sel]] + AW'(1);
                is_valid[k] = 1'b1;
                is_tag[k] = tag_q[sel];
                is_src_val[k] = val_q[sel];
                is_fu[k] = fu_q[sel];
                is_payload[k] = pay_q[sel];
            end
        end
    end

    always_comb begin
        valid_d = valid_q & ~issued;
        tag_d = tag_q;
        rdy_d = rdy_q;
        stag_d = stag_q;
        val_d = val_q;
        fu_d = fu_q;
        pay_d = pay_q;
        ovf_d = ovf_q;
        alloc = '0;
        slot_hit = 1'b0;
        slot = '0;
`ifdef RS_AGE_ORDER_EN
        age_d = age_q;
`endif
        // descending CDB scan lets the lowest matching lane win
        for (int i = 0; i < RS_DEPTH; i++)
            for (int s = 0; s < 2; s++)
                for (int c = CDB_WIDTH - 1; c >= 0; c--)
                    if (valid_q[i] && !rdy_q[i][s] && cdb_valid[c] && cdb_tag[c] == stag_q[i][s]) begin
                        rdy_d[i][s] = 1'b1;
                        val_d[i][s] = cdb_val[c];
                    end
        if (squash)
            valid_d = '0;
        else
            for (int l = 0; l < DP_WIDTH; l++)
                if (dp_valid[l]) begin
                    slot_hit = 1'b0;
                    slot = '0;
                    for (int i = RS_DEPTH - 1; i >= 0; i--)
                        if (!valid_q[i] && !alloc[i]) begin
                            slot_hit = 1'b1;
                            slot = IW'(i);
                        end
                    if (!slot_hit)
                        ovf_d = 1'b1;
                    else begin
                        valid_d[slot] = 1'b1;
                        tag_d[slot] = dp_tag[l];
                        fu_d[slot] = dp_fu[l];
                        pay_d[slot] = dp_payload[l];
                        for (int s = 0; s < 2; s++) begin
                            rdy_d[slot][s] = dp_src_rdy[l][s];
                            stag_d[slot][s] = dp_src_tag[l][s];
                            val_d[slot][s] = dp_src_val[l][s];
                            for (int c = CDB_WIDTH - 1; c >= 0; c--)
                                if (!dp_src_rdy[l][s] && cdb_valid[c] && cdb_tag[c] == dp_src_tag[l][s]) begin
                                    rdy_d[slot][s] = 1'b1;
                                    val_d[slot][s] = cdb_val[c];
                                end
                        end
`ifdef RS_AGE_ORDER_EN
                        // new entry is younger than everything live, including lower lanes this cycle
                        for (int i = 0; i < RS_DEPTH; i++)
                            age_d[i][slot] = 1'b0;
                        age_d[slot] = valid_q | alloc;
`endif
                        alloc[slot] = 1'b1;
                    end
                end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q <= '0;
            rdy_q <= '0;
            stag_q <= '0;
            val_q <= '0;
            fu_q <= '0;
            pay_q <= '0;
            ovf_q <= 1'b0;
`ifdef RS_AGE_ORDER_EN
            age_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            tag_q <= tag_d;
            rdy_q <= rdy_d;
            stag_q <= stag_d;
            val_q <= val_d;
            fu_q <= fu_d;
            pay_q <= pay_d;
            ovf_q <= ovf_d;
`ifdef RS_AGE_ORDER_EN
            age_q <= age_d;
`endif
        end
    end
endmodule

// File: tb/tb_rs_age_issue.sv
// tb_rs_age_issue: directed bench for rs_age_issue with an issue-order scoreboard.
module tb_rs_age_issue;
    localparam logic [1:0] ALU = 2'd0, MULT = 2'd1, BR = 2'd3;

    logic clk = 1'b0, rst_n = 1'b0, squash;
    logic [2:0]            dp_valid;
    logic [2:0][4:0]       dp_tag;
    logic [2:0][1:0]       dp_src_rdy;
    logic [2:0][1:0][4:0]  dp_src_tag;
    logic [2:0][1:0][31:0] dp_src_val;
    logic [2:0][1:0]       dp_fu;
    logic [2:0][63:0]      dp_payload;
    logic [2:0]            cdb_valid;
    logic [2:0][4:0]       cdb_tag;
    logic [2:0][31:0]      cdb_val;
    logic [3:0][1:0]       fu_avail;
    logic [1:0]            free_num;
    logic [2:0]            is_valid;
    logic [2:0][4:0]       is_tag;
    logic [2:0][1:0][31:0] is_src_val;
    logic [2:0][1:0]       is_fu;
    logic [2:0][63:0]      is_payload;
    logic                  overflow_err;

    typedef struct packed {
        logic [4:0]  tag;
        logic [1:0]  fu;
        logic [31:0] v0;
        logic [31:0] v1;
    } exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0;

    rs_age_issue dut (
        .clk(clk), .rst_n(rst_n), .squash(squash),
        .dp_valid(dp_valid), .dp_tag(dp_tag), .dp_src_rdy(dp_src_rdy), .dp_src_tag(dp_src_tag),
        .dp_src_val(dp_src_val), .dp_fu(dp_fu), .dp_payload(dp_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .fu_avail(fu_avail),
        .free_num(free_num), .is_valid(is_valid), .is_tag(is_tag), .is_src_val(is_src_val),
        .is_fu(is_fu), .is_payload(is_payload), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pay_of(input logic [4:0] t);
        return {32'hFACE0000, 27'd0, t};
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        squash = 1'b0;
        dp_valid = '0; dp_tag = '0; dp_src_rdy = '0; dp_src_tag = '0;
        dp_src_val = '0; dp_fu = '0; dp_payload = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    task automatic avail(input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] a3);
        fu_avail = {a3, a2, a1, a0};
    endtask

    task automatic lane(input int l, input logic [4:0] tag, input logic [1:0] fu,
                        input logic r0, input logic [4:0] t0, input logic [31:0] v0,
                        input logic r1, input logic [4:0] t1, input logic [31:0] v1);
        dp_valid[l] = 1'b1;
        dp_tag[l] = tag;
        dp_fu[l] = fu;
        dp_src_rdy[l] = {r1, r0};
        dp_src_tag[l][0] = t0;
        dp_src_tag[l][1] = t1;
        dp_src_val[l][0] = v0;
        dp_src_val[l][1] = v1;
        dp_payload[l] = pay_of(tag);
    endtask

    task automatic cdb(input int c, input logic [4:0] tag, input logic [31:0] val);
        cdb_valid[c] = 1'b1;
        cdb_tag[c] = tag;
        cdb_val[c] = val;
    endtask

    task automatic push(input logic [4:0] tag, input logic [1:0] fu, input logic [31:0] v0, input logic [31:0] v1);
        exp_t e;
        e.tag = tag; e.fu = fu; e.v0 = v0; e.v1 = v1;
        sb.push_back(e);
    endtask

    // settle, then compare every issue port against the scoreboard in port order
    task automatic sample(input string nm, input int n);
        exp_t e;
        #1;
        chk({nm, " nvalid"}, 64'($countones(is_valid)), 64'(n));
        for (int k = 0; k < 3; k++) begin
            if (is_valid[k]) begin
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL %s unexpected_issue: got tag %0h expected none", nm, is_tag[k]);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({nm, " tag"}, 64'(is_tag[k]), 64'(e.tag));
                    chk({nm, " fu"}, 64'(is_fu[k]), 64'(e.fu));
                    chk({nm, " src0"}, 64'(is_src_val[k][0]), 64'(e.v0));
                    chk({nm, " src1"}, 64'(is_src_val[k][1]), 64'(e.v1));
                    chk({nm, " payload"}, is_payload[k], pay_of(e.tag));
                end
            end else
                chk({nm, " idle_data"}, 64'(|{is_tag[k], is_src_val[k], is_fu[k], is_payload[k]}), 64'(0));
        end
    endtask

    initial begin
        int exp_free[6] = '{3, 3, 3, 3, 3, 1};
        idle();
        avail(0, 0, 0, 0);
        #12;
        sample("reset", 0);
        chk("reset free_num", 64'(free_num), 64'(3));
        chk("reset overflow", 64'(overflow_err), 64'(0));
        rst_n = 1'b1;
        cyc();

        for (int c = 0; c < 6; c++) begin
            idle();
            for (int l = 0; l < 3; l++) lane(l, 5'(c * 3 + l), ALU, 1, 0, 32'(c), 1, 0, 32'(l));
            sample("fill", 0);
            chk("fill free_num", 64'(free_num), 64'(exp_free[c]));
            chk("fill overflow", 64'(overflow_err), 64'(0));
            cyc();
        end
        idle();
        #1;
        chk("full free_num", 64'(free_num), 64'(0));
        chk("full overflow", 64'(overflow_err), 64'(1));

        squash = 1'b1;
        for (int l = 0; l < 3; l++) lane(l, 5'(28 + l), ALU, 1, 0, 32'h5, 1, 0, 32'h6);
        avail(3, 3, 3, 3);
        sample("squash", 0);
        cyc();
        idle();
        sample("post_squash", 0);
        chk("post_squash free_num", 64'(free_num), 64'(3));
        chk("post_squash overflow", 64'(overflow_err), 64'(1));
        cyc();
        sample("post_squash2", 0);

        avail(1, 0, 0, 0);
        lane(0, 5'd20, ALU, 0, 5'd7, 32'h0, 0, 5'd8, 32'h0);
        cdb(0, 5'd7, 32'hABCD);
        cdb(1, 5'd8, 32'h1111);
        cdb(2, 5'd8, 32'h2222);
        push(5'd20, ALU, 32'hABCD, 32'h1111);
        sample("bypass_dp", 0);
        cyc();
        idle();
        sample("bypass_issue", 1);
        cyc();
        sample("bypass_after", 0);

        avail(0, 0, 0, 0);
        lane(0, 5'd1, BR, 1, 0, 32'h11, 1, 0, 32'h12);
        lane(1, 5'd2, ALU, 0, 5'd10, 32'h0, 1, 0, 32'hA1);
        sample("age0", 0);
        cyc();
        idle();
        avail(0, 0, 0, 1);
        push(5'd1, BR, 32'h11, 32'h12);
        sample("age1", 1);
        cyc();
        avail(0, 0, 0, 0);
        lane(0, 5'd3, ALU, 0, 5'd11, 32'h0, 1, 0, 32'hB1);
        sample("age2", 0);
        cyc();
        idle();
        cdb(0, 5'd11, 32'hB0);
        sample("age3", 0);
        cyc();
        idle();
        cdb(0, 5'd10, 32'hA0);
        sample("age4", 0);
        cyc();
        idle();
        avail(1, 0, 0, 0);
`ifdef RS_AGE_ORDER_EN
        push(5'd2, ALU, 32'hA0, 32'hA1);
        sample("age5", 1);
        cyc();
        push(5'd3, ALU, 32'hB0, 32'hB1);
`else
        push(5'd3, ALU, 32'hB0, 32'hB1);
        sample("age5", 1);
        cyc();
        push(5'd2, ALU, 32'hA0, 32'hA1);
`endif
        sample("age6", 1);
        cyc();
        sample("age7", 0);

        avail(3, 1, 0, 0);
        for (int l = 0; l < 3; l++) begin
            lane(l, 5'(24 + l), MULT, 1, 0, 32'(100 + l), 1, 0, 32'(200 + l));
            push(5'(24 + l), MULT, 32'(100 + l), 32'(200 + l));
        end
        sample("cap0", 0);
        cyc();
        idle();
        lane(0, 5'd27, MULT, 1, 0, 32'd103, 1, 0, 32'd203);
        push(5'd27, MULT, 32'd103, 32'd203);
        sample("cap1", 1);
        cyc();
        idle();
        sample("cap2", 1);
        cyc();
        sample("cap3", 1);
        cyc();
        sample("cap4", 1);
        cyc();
        sample("cap5", 0);

        avail(0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            idle();
            for (int l = 0; l < 3; l++) lane(l, 5'(c * 3 + l), ALU, 1, 0, 32'h7, 1, 0, 32'h8);
            cyc();
        end
        idle();
        #1;
        chk("pre_areset free_num", 64'(free_num), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("areset free_num", 64'(free_num), 64'(3));
        chk("areset overflow", 64'(overflow_err), 64'(0));
        avail(3, 3, 3, 3);
        sample("areset", 0);
        #1;
        rst_n = 1'b1;
        cyc();
        sample("post_reset", 0);
        chk("post_reset free_num", 64'(free_num), 64'(3));
        chk("scoreboard drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
